// File: rtl/apb_package.sv
// Shared definitions for the multi-channel APB UART CSR block: register offsets,
// channel stride, configuration reset values and the transfer FSM states.
package apb_package;

    typedef enum logic [7:0] {
        OFF_TDR = 8'h00,
        OFF_RDR = 8'h04,
        OFF_LCR = 8'h08,
        OFF_OCR = 8'h0C,
        OFF_LSR = 8'h10,
        OFF_FCR = 8'h14,
        OFF_MSR = 8'h18,
        OFF_MCR = 8'h1C,
        OFF_IER = 8'h20,
        OFF_IIR = 8'h24
    } apb_addr_e;

    localparam logic [11:0] CH_STRIDE = 12'h100;
    localparam logic [7:0]  LCR_RST   = 8'h03;
    localparam logic [15:0] OCR_RST   = 16'h0010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_fsm_e;

    function automatic logic off_mapped(input logic [7:0] off);
        case (off)
            OFF_TDR, OFF_RDR, OFF_LCR, OFF_OCR, OFF_LSR,
            OFF_FCR, OFF_MSR, OFF_MCR, OFF_IER, OFF_IIR: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    function automatic logic off_read_only(input logic [7:0] off);
        case (off)
            OFF_RDR, OFF_LSR, OFF_MSR, OFF_IIR: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/apb_uart_ch_regs.sv
// One UART channel's configuration bank (LCR/OCR/FCR/MCR/IER) and its read mux.
// Writes arrive already qualified (legal, addressed to this channel, pready cycle).
module apb_uart_ch_regs
    import apb_package::*;
(
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic        wr_en_i,
    input  logic [7:0]  off_i,
    input  logic [15:0] wdata_i,
    input  logic [1:0]  be_i,
    input  logic [7:0]  rx_data_i,
    input  logic [7:0]  lsr_i,
    input  logic [7:0]  msr_i,
    input  logic [7:0]  iir_i,
    output logic [15:0] rd_data_o,
    output logic [7:0]  lcr_o,
    output logic [7:0]  fcr_o,
    output logic [7:0]  mcr_o,
    output logic [7:0]  ier_o,
    output logic [15:0] ocr_o
);

    logic [7:0]  lcr_q, lcr_d;
    logic [7:0]  fcr_q, fcr_d;
    logic [7:0]  mcr_q, mcr_d;
    logic [7:0]  ier_q, ier_d;
    logic [15:0] ocr_q, ocr_d;

    always_comb begin
        lcr_d = lcr_q;
        fcr_d = fcr_q;
        mcr_d = mcr_q;
        ier_d = ier_q;
        ocr_d = ocr_q;
        if (wr_en_i) begin
            case (off_i)
                OFF_LCR: if (be_i[0]) lcr_d = wdata_i[7:0];
                OFF_OCR: begin
                    if (be_i[0]) ocr_d[7:0]  = wdata_i[7:0];
                    if (be_i[1]) ocr_d[15:8] = wdata_i[15:8];
                end
                OFF_FCR: if (be_i[0]) fcr_d = wdata_i[7:0];
                OFF_MCR: if (be_i[0]) mcr_d = wdata_i[7:0];
                OFF_IER: if (be_i[0]) ier_d = wdata_i[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            lcr_q <= LCR_RST;
            ocr_q <= OCR_RST;
            fcr_q <= '0;
            mcr_q <= '0;
            ier_q <= '0;
        end else begin
            lcr_q <= lcr_d;
            ocr_q <= ocr_d;
            fcr_q <= fcr_d;
            mcr_q <= mcr_d;
            ier_q <= ier_d;
        end
    end

    // TDR is write-only, so it falls through to zero with the unmapped offsets.
    always_comb begin
        rd_data_o = '0;
        case (off_i)
            OFF_RDR: rd_data_o = {8'h00, rx_data_i};
            OFF_LCR: rd_data_o = {8'h00, lcr_q};
            OFF_OCR: rd_data_o = ocr_q;
            OFF_LSR: rd_data_o = {8'h00, lsr_i};
            OFF_FCR: rd_data_o = {8'h00, fcr_q};
            OFF_MSR: rd_data_o = {8'h00, msr_i};
            OFF_MCR: rd_data_o = {8'h00, mcr_q};
            OFF_IER: rd_data_o = {8'h00, ier_q};
            OFF_IIR: rd_data_o = {8'h00, iir_i};
            default: rd_data_o = '0;
        endcase
    end

    assign lcr_o = lcr_q;
    assign fcr_o = fcr_q;
    assign mcr_o = mcr_q;
    assign ier_o = ier_q;
    assign ocr_o = ocr_q;

endmodule

// File: rtl/apb_uart_mch_csr.sv
// APB slave CSR block for NUM_CH UART channels with programmable wait states.
// Define APB_UART_WSTRB_EN to honour pstrb[1:0] as byte enables; otherwise writes are full-width.
module apb_uart_mch_csr
    import apb_package::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    output logic                  pready,
    output logic                  pslverr,
    output logic [DATA_W-1:0]     prdata,
    output logic [NUM_CH-1:0]     tx_push,
    output logic [NUM_CH*8-1:0]   tx_data,
    input  logic [NUM_CH-1:0]     tx_full,
    output logic [NUM_CH-1:0]     rx_pop,
    input  logic [NUM_CH*8-1:0]   rx_data,
    input  logic [NUM_CH-1:0]     rx_empty,
    input  logic [NUM_CH*8-1:0]   lsr_i,
    input  logic [NUM_CH*8-1:0]   msr_i,
    input  logic [NUM_CH*8-1:0]   iir_i,
    output logic [NUM_CH*8-1:0]   lcr_o,
    output logic [NUM_CH*8-1:0]   fcr_o,
    output logic [NUM_CH*8-1:0]   mcr_o,
    output logic [NUM_CH*8-1:0]   ier_o,
    output logic [NUM_CH*16-1:0]  ocr_o
);

    localparam int         CH_W      = ADDR_W - 8;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    apb_fsm_e          state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              latch_en;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [15:0]       wdata_q;
    logic [1:0]        be_q, be_in;

    `ifdef APB_UART_WSTRB_EN
    assign be_in = pstrb[1:0];
    `else
    assign be_in = 2'b11;
    `endif

    // Only the low 16 data bits and two strobes can reach any register.
    logic unused_bits;
    assign unused_bits = ^{pwdata >> 16, pstrb};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    latch_en = 1'b1;
                    cnt_d    = WAIT_INIT;
                    state_d  = (WAIT_CYCLES == 0) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata[15:0];
                be_q    <= be_in;
            end
        end
    end

    logic [CH_W-1:0] ch_field;
    logic [31:0]     ch_idx;
    logic [7:0]      off;
    logic            ch_valid, is_tdr, is_rdr;
    logic            sel_tx_full, sel_rx_empty;
    logic [15:0]     sel_rd;
    logic [15:0]     ch_rd [NUM_CH];
    logic            err, fire, ok_fire;

    assign ch_field = addr_q[ADDR_W-1:8];
    assign ch_idx   = 32'(ch_field);
    assign off      = addr_q[7:0];
    assign ch_valid = ch_idx < 32'(NUM_CH);
    assign is_tdr   = off == OFF_TDR;
    assign is_rdr   = off == OFF_RDR;

    always_comb begin
        sel_tx_full  = 1'b0;
        sel_rx_empty = 1'b0;
        sel_rd       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == 32'(i)) begin
                sel_tx_full  = tx_full[i];
                sel_rx_empty = rx_empty[i];
                sel_rd       = ch_rd[i];
            end
        end
    end

    // Unaligned addresses never match a mapped offset, so off_mapped covers them too.
    assign err = !ch_valid
              || !off_mapped(off)
              || (write_q && off_read_only(off))
              || (!write_q && is_tdr)
              || (write_q && is_tdr && (sel_tx_full || !be_q[0]))
              || (!write_q && is_rdr && sel_rx_empty);

    assign fire    = (state_q == DONE) && psel;
    assign ok_fire = fire && !err;

    assign pready  = fire;
    assign pslverr = fire && err;
    assign prdata  = (ok_fire && !write_q) ? DATA_W'(sel_rd) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic hit;
            assign hit                 = ok_fire && (ch_idx == 32'(gi));
            assign tx_push[gi]         = hit && write_q && is_tdr;
            assign rx_pop[gi]          = hit && !write_q && is_rdr;
            assign tx_data[gi*8 +: 8]  = wdata_q[7:0];

            apb_uart_ch_regs u_regs (
                .clk_i     (pclk),
                .srst_i    (preset),
                .wr_en_i   (hit && write_q),
                .off_i     (off),
                .wdata_i   (wdata_q),
                .be_i      (be_q),
                .rx_data_i (rx_data[gi*8 +: 8]),
                .lsr_i     (lsr_i[gi*8 +: 8]),
                .msr_i     (msr_i[gi*8 +: 8]),
                .iir_i     (iir_i[gi*8 +: 8]),
                .rd_data_o (ch_rd[gi]),
                .lcr_o     (lcr_o[gi*8 +: 8]),
                .fcr_o     (fcr_o[gi*8 +: 8]),
                .mcr_o     (mcr_o[gi*8 +: 8]),
                .ier_o     (ier_o[gi*8 +: 8]),
                .ocr_o     (ocr_o[gi*16 +: 16])
            );
        end
    endgenerate

endmodule

// File: tb/tb_apb_uart_mch_csr.sv
// Bench for apb_uart_mch_csr: directed vector table, reset/abort sequences and
// randomized transfers checked against a register-map model kept in the bench.
module tb_apb_uart_mch_csr;
    import apb_package::*;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int WAIT_C = 2;

    logic                 pclk = 1'b0;
    logic                 preset, psel, penable, pwrite;
    logic [ADDR_W-1:0]    paddr;
    logic [DATA_W-1:0]    pwdata;
    logic [DATA_W/8-1:0]  pstrb;
    logic                 pready, pslverr;
    logic [DATA_W-1:0]    prdata;
    logic [NUM_CH-1:0]    tx_push, tx_full, rx_pop, rx_empty;
    logic [NUM_CH*8-1:0]  tx_data, rx_data, lsr_i, msr_i, iir_i;
    logic [NUM_CH*8-1:0]  lcr_o, fcr_o, mcr_o, ier_o;
    logic [NUM_CH*16-1:0] ocr_o;

    apb_uart_mch_csr #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT_C)
    ) dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .pslverr(pslverr),
        .prdata(prdata), .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full),
        .rx_pop(rx_pop), .rx_data(rx_data), .rx_empty(rx_empty), .lsr_i(lsr_i),
        .msr_i(msr_i), .iir_i(iir_i), .lcr_o(lcr_o), .fcr_o(fcr_o), .mcr_o(mcr_o),
        .ier_o(ier_o), .ocr_o(ocr_o)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_errs   = 0;
    int n_txn    = 0;

    // Reference state: config registers and the channel-side status inputs.
    logic [7:0]  m_lcr [NUM_CH];
    logic [7:0]  m_fcr [NUM_CH];
    logic [7:0]  m_mcr [NUM_CH];
    logic [7:0]  m_ier [NUM_CH];
    logic [15:0] m_ocr [NUM_CH];
    bit          m_txf [NUM_CH];
    bit          m_rxe [NUM_CH];
    logic [7:0]  m_rxd [NUM_CH];
    logic [7:0]  m_lsr [NUM_CH];
    logic [7:0]  m_msr [NUM_CH];
    logic [7:0]  m_iir [NUM_CH];

    int offs [10] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h18, 'h1C, 'h20, 'h24};

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          txf;
        bit          rxe;
        logic [7:0]  rxd;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs [17];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_lcr[i] = 8'h03; m_ocr[i] = 16'h0010;
            m_fcr[i] = 8'h00; m_mcr[i] = 8'h00; m_ier[i] = 8'h00;
        end
    endtask

    task automatic drive_status();
        for (int i = 0; i < NUM_CH; i++) begin
            tx_full[i]          = m_txf[i];
            rx_empty[i]         = m_rxe[i];
            rx_data[i*8 +: 8]   = m_rxd[i];
            lsr_i[i*8 +: 8]     = m_lsr[i];
            msr_i[i*8 +: 8]     = m_msr[i];
            iir_i[i*8 +: 8]     = m_iir[i];
        end
    endtask

    task automatic check_cfg();
        logic [31:0] e_lcr, e_fcr, e_mcr, e_ier;
        logic [63:0] e_ocr;
        for (int i = 0; i < NUM_CH; i++) begin
            e_lcr[i*8 +: 8]   = m_lcr[i];
            e_fcr[i*8 +: 8]   = m_fcr[i];
            e_mcr[i*8 +: 8]   = m_mcr[i];
            e_ier[i*8 +: 8]   = m_ier[i];
            e_ocr[i*16 +: 16] = m_ocr[i];
        end
        chk("cfg_lcr", 64'(lcr_o), 64'(e_lcr));
        chk("cfg_fcr", 64'(fcr_o), 64'(e_fcr));
        chk("cfg_mcr", 64'(mcr_o), 64'(e_mcr));
        chk("cfg_ier", 64'(ier_o), 64'(e_ier));
        chk("cfg_ocr", ocr_o, e_ocr);
    endtask

    // Register-map rules applied to one completed transfer.
    task automatic model_txn(input bit wr, input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, output bit err, output logic [31:0] rd,
                             output logic [NUM_CH-1:0] push, output logic [NUM_CH-1:0] pop);
        int ch, off;
        bit b0, b1;
        ch  = int'(a) / int'(CH_STRIDE);
        off = int'(a) % int'(CH_STRIDE);
        `ifdef APB_UART_WSTRB_EN
        b0 = s[0]; b1 = s[1];
        `else
        b0 = 1'b1; b1 = 1'b1;
        `endif
        err = 1'b0; rd = '0; push = '0; pop = '0;
        if (ch >= NUM_CH) begin
            err = 1'b1;
        end else if (wr) begin
            case (off)
                'h00: if (m_txf[ch] || !b0) err = 1'b1; else push[ch] = 1'b1;
                'h08: if (b0) m_lcr[ch] = d[7:0];
                'h0C: begin
                    if (b0) m_ocr[ch][7:0]  = d[7:0];
                    if (b1) m_ocr[ch][15:8] = d[15:8];
                end
                'h14: if (b0) m_fcr[ch] = d[7:0];
                'h1C: if (b0) m_mcr[ch] = d[7:0];
                'h20: if (b0) m_ier[ch] = d[7:0];
                default: err = 1'b1;
            endcase
        end else begin
            case (off)
                'h04: if (m_rxe[ch]) err = 1'b1;
                      else begin rd = {24'h0, m_rxd[ch]}; pop[ch] = 1'b1; end
                'h08: rd = {24'h0, m_lcr[ch]};
                'h0C: rd = {16'h0, m_ocr[ch]};
                'h10: rd = {24'h0, m_lsr[ch]};
                'h14: rd = {24'h0, m_fcr[ch]};
                'h18: rd = {24'h0, m_msr[ch]};
                'h1C: rd = {24'h0, m_mcr[ch]};
                'h20: rd = {24'h0, m_ier[ch]};
                'h24: rd = {24'h0, m_iir[ch]};
                default: err = 1'b1;
            endcase
        end
    endtask

    // One APB transfer; leaves psel high so a following call is back-to-back.
    task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, output bit got_err, output logic [31:0] got_rd);
        int cyc;
        bit e_err;
        logic [31:0] e_rd;
        logic [NUM_CH-1:0] e_push, e_pop;
        got_err = 1'b0; got_rd = '0;
        @(posedge pclk); #1;
        drive_status();
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(negedge pclk);
        chk("setup_quiet", 64'({pready, tx_push, rx_pop}), 64'd0);
        check_cfg();
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc = 1;
        @(negedge pclk);
        while (!pready && cyc < 20) begin
            @(negedge pclk);
            cyc++;
        end
        n_txn++;
        if (!pready) begin
            n_checks++; n_errs++;
            $display("FAIL pready_timeout: got no pready after %0d cycles, expected %0d", cyc, WAIT_C + 1);
            @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
        end else begin
            model_txn(wr, a, d, s, e_err, e_rd, e_push, e_pop);
            got_err = pslverr;
            got_rd  = prdata;
            $display("txn %0d wr=%0b addr=0x%03h wdata=0x%08h strb=%b -> pslverr=%0b prdata=0x%08h push=%b pop=%b",
                     n_txn, wr, a, d, s, pslverr, prdata, tx_push, rx_pop);
            chk("latency", 64'(cyc), 64'(WAIT_C + 1));
            chk("pslverr", 64'(pslverr), 64'(e_err));
            chk("prdata", 64'(prdata), 64'(e_rd));
            chk("tx_push", 64'(tx_push), 64'(e_push));
            chk("rx_pop", 64'(rx_pop), 64'(e_pop));
            for (int i = 0; i < NUM_CH; i++)
                if (e_push[i]) chk("tx_data", 64'(tx_data[i*8 +: 8]), 64'(d[7:0]));
        end
    endtask

    task automatic idle_cyc();
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        chk("idle_quiet", 64'({pready, tx_push, rx_pop}), 64'd0);
        check_cfg();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          g_err;
        logic [31:0] g_rd;
        logic [31:0] ocr_exp;
        int          ch, off, k;

        `ifdef APB_UART_WSTRB_EN
        ocr_exp = 32'h0000AB10;
        `else
        ocr_exp = 32'h0000ABCD;
        `endif
        vecs[0]  = '{1'b0, 12'h00C, 32'h0,        4'hF, 1'b0, 1'b0, 8'h00, 1'b0, 32'h10};
        vecs[1]  = '{1'b1, 12'h108, 32'h1B,       4'hF, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 12'h108, 32'h0,        4'hF, 1'b0, 1'b0, 8'h00, 1'b0, 32'h1B};
        vecs[3]  = '{1'b1, 12'h000, 32'h5A,       4'hF, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 12'h000, 32'h5A,       4'hF, 1'b1, 1'b0, 8'h00, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 12'h204, 32'h0,        4'hF, 1'b0, 1'b0, 8'h77, 1'b0, 32'h77};
        vecs[6]  = '{1'b0, 12'h204, 32'h0,        4'hF, 1'b0, 1'b1, 8'h77, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 12'h400, 32'h0,        4'hF, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 12'h028, 32'h0,        4'hF, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 12'h009, 32'h0,        4'hF, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 12'h010, 32'hFF,       4'hF, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 12'h000, 32'h0,        4'hF, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0};
        vecs[12] = '{1'b1, 12'h00C, 32'hABCD,     4'h2, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 12'h00C, 32'h0,        4'hF, 1'b0, 1'b0, 8'h00, 1'b0, ocr_exp};
        vecs[14] = '{1'b0, 12'h010, 32'h0,        4'hF, 1'b0, 1'b0, 8'h00, 1'b0, 32'h60};
        vecs[15] = '{1'b1, 12'h314, 32'hC7,       4'hF, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 12'h314, 32'h0,        4'hF, 1'b0, 1'b0, 8'h00, 1'b0, 32'hC7};

        for (int i = 0; i < NUM_CH; i++) begin
            m_txf[i] = 1'b0; m_rxe[i] = 1'b1; m_rxd[i] = 8'h00;
            m_lsr[i] = 8'h60; m_msr[i] = 8'h00; m_iir[i] = 8'h01;
        end
        drive_status();
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;
        model_reset();
        @(negedge pclk);
        chk("rst_pready", 64'(pready), 64'd0);
        chk("rst_pslverr", 64'(pslverr), 64'd0);
        chk("rst_prdata", 64'(prdata), 64'd0);
        chk("rst_pulses", 64'({tx_push, rx_pop}), 64'd0);
        check_cfg();

        // Directed vectors (latency of every transfer is also checked inside xfer).
        for (int v = 0; v < 17; v++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_txf[i] = vecs[v].txf; m_rxe[i] = vecs[v].rxe; m_rxd[i] = vecs[v].rxd;
            end
            xfer(vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].strb, g_err, g_rd);
            chk("vec_err", 64'(g_err), 64'(vecs[v].exp_err));
            chk("vec_rdata", 64'(g_rd), 64'(vecs[v].exp_rd));
        end
        idle_cyc();
        chk("lcr_ch1", 64'(lcr_o[15:8]), 64'h1B);

        // Reset asserted during the wait states of an IER write.
        xfer(1'b1, 12'h320, 32'h05, 4'hF, g_err, g_rd);
        idle_cyc();
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h320; pwdata = 32'h3C; pstrb = 4'hF;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1 preset = 1'b1;
        @(negedge pclk);
        chk("rst_mid_pready", 64'(pready), 64'd0);
        @(posedge pclk); #1 preset = 1'b0;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge pclk);
            chk("no_setup_pready", 64'(pready), 64'd0);
        end
        chk("rst_mid_ier", 64'(ier_o[31:24]), 64'h00);
        check_cfg();
        idle_cyc();

        // psel dropped during the wait states: the MCR write must not happen.
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h11C; pwdata = 32'hEE; pstrb = 4'hF;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge pclk);
            chk("abort_pready", 64'(pready), 64'd0);
        end
        chk("abort_mcr", 64'(mcr_o[15:8]), 64'h00);
        idle_cyc();

        // Randomized traffic, back-to-back with occasional idle gaps.
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_txf[i] = ($urandom_range(0, 3) == 0);
                m_rxe[i] = ($urandom_range(0, 3) == 0);
                m_rxd[i] = 8'($urandom);
                m_lsr[i] = 8'($urandom);
                m_msr[i] = 8'($urandom);
                m_iir[i] = 8'($urandom);
            end
            ch = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
            k  = int'($urandom_range(0, 11));
            if (k < 10)       off = offs[k];
            else if (k == 10) off = int'($urandom_range(0, 255));
            else              off = offs[$urandom_range(0, 9)] + int'($urandom_range(1, 3));
            xfer(1'($urandom), 12'(ch * 256 + off), $urandom, 4'($urandom), g_err, g_rd);
            if ($urandom_range(0, 3) == 0) idle_cyc();
        end
        idle_cyc();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
